ofd_pipe_reg: RTL and testbench
===============================

// Module: ofd_pipe_reg
// PURPOSE
// - Parametrised output-register bank for ECP3 I/O simulation models.
// - Generalises the single-bit, single-stage output flip-flop to WIDTH lanes and DEPTH pipeline stages.
// - Adds clock enable, synchronous local clear, a depth-matched tristate-enable pipe and a fill/valid tracker.
// - Sits between fabric logic and the pad buffers; Q/QOE feed the output and tristate buffers.
// PARAMETERS
// - WIDTH        8           number of data lanes (1..64)
// - DEPTH        2           pipeline stages, D to Q (1..8)
// - INIT         {WIDTH{0}}  value loaded into every data stage on RST or LSR
// - LSR_OVER_CE  "ENABLED"   "ENABLED": LSR acts even when CE=0; "DISABLED": LSR acts only when CE=1
// PORTS
// - SCLK    in   1      clock; all state updates on rising edge
// - RST     in   1      asynchronous reset, active-high
// - CE      in   1      clock enable for all stages, counter and OE pipe
// - LSR     in   1      synchronous local clear, active-high
// - D       in   WIDTH  data in
// - OE_IN   in   1      output-drive request, 1 = drive pad
// - Q       out  WIDTH  registered data out (last stage)
// - QOE     out  1      registered drive enable, delay-matched to Q
// - QVALID  out  1      1 once DEPTH enabled captures have occurred since the last RST or LSR
// BEHAVIOUR
// - State:
//   - data stages s[0..DEPTH-1], each WIDTH bits
//   - OE stages o[0..DEPTH-1], 1 bit each
//   - fill counter cnt, $clog2(DEPTH+1) bits
// - RST=1 (async, immediate, dominates everything):
//   - s[*]=INIT, o[*]=0, cnt=0
//   - outputs: Q=INIT, QOE=0, QVALID=0
//   - RST deassertion takes effect at the next rising edge after release; no edge is sampled while RST=1
// - LSR at rising edge, when active per LSR_OVER_CE:
//   - same state as RST
//   - wins over a simultaneous CE capture
// - Enabled capture (CE=1, no LSR, rising edge):
//   - s[0]<=D, o[0]<=OE_IN
//   - s[i]<=s[i-1], o[i]<=o[i-1] for i=1..DEPTH-1
//   - cnt<=min(cnt+1, DEPTH), saturating with no wrap
// - CE=0 (and no LSR action): all state holds, including cnt.
// - LSR with LSR_OVER_CE="DISABLED" and CE=0: ignored; state holds.
// - Outputs are direct register outputs, with no combinational path from any input:
//   - Q=s[DEPTH-1], QOE=o[DEPTH-1], QVALID=(cnt==DEPTH)
// - Latency: D/OE_IN sampled at enabled edge k appear on Q/QOE after enabled edge k+DEPTH-1.
//   - Disabled edges stretch latency in wall-clock time only.
// - DEPTH=1: single-stage register (Q follows D one edge later when CE=1); QVALID rises after the first enabled edge.
// - X on D propagates lane-wise only. X on CE or LSR drives affected state to X (pessimistic).
// - QVALID, once high, stays high until RST or LSR; the counter never wraps.
// TESTING
// - Reset/init: WIDTH=8, DEPTH=3, INIT=8'hA5; assert RST mid-stream with data in flight ->
//   - Q=8'hA5, QOE=0, QVALID=0 immediately, before any edge
//   - no edge is sampled while RST=1
// - Latency/fill: CE=1, D=01,02,03,04 on successive edges, OE_IN=1 ->
//   - Q=01 and QOE=1 after the 3rd edge; QVALID=1 from that same edge
//   - Q=02 after the 4th edge
// - CE stall: after 1 enabled edge, hold CE=0 for 5 edges, then resume ->
//   - Q, QOE and cnt frozen during the stall
//   - first data reaches Q after exactly 2 more enabled edges
// - LSR priority: DEPTH=2, full pipe, CE=0, LSR=1 one edge ->
//   - LSR_OVER_CE="ENABLED": Q=INIT, QVALID=0
//   - "DISABLED": Q unchanged, QVALID=1
// - Simultaneous: CE=1 and LSR=1 on the same edge with D=FF -> Q=INIT, cnt=0; FF is never seen on Q.
// - DEPTH=1, WIDTH=1 corner: toggle D each edge -> Q equals D delayed one edge; QVALID=1 after the first edge.

Source files
------------

// File: rtl/ofd_pipe_reg.sv
// Output-register bank for I/O models: WIDTH lanes by DEPTH stages, with clock enable,
// synchronous local clear, a delay-matched drive-enable pipe and a saturating fill tracker.
module ofd_pipe_reg #(
  parameter int unsigned      WIDTH       = 8,
  parameter int unsigned      DEPTH       = 2,
  parameter logic [WIDTH-1:0] INIT        = '0,
  parameter string            LSR_OVER_CE = "ENABLED"
) (
  input  logic             SCLK,
  input  logic             RST,
  input  logic             CE,
  input  logic             LSR,
  input  logic [WIDTH-1:0] D,
  input  logic             OE_IN,
  output logic [WIDTH-1:0] Q,
  output logic             QOE,
  output logic             QVALID
);

  localparam int unsigned     CntW      = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] CntFull   = CntW'(DEPTH);
  localparam bit              LsrOverCe = (LSR_OVER_CE == "ENABLED");

  logic [WIDTH-1:0] s_q  [DEPTH];
  logic [WIDTH-1:0] s_d  [DEPTH];
  logic [WIDTH-1:0] s_in [DEPTH];
  logic [DEPTH-1:0] o_q, o_d, o_in;
  logic [CntW-1:0]  cnt_q, cnt_d, cnt_inc;
  logic             lsr_act;

  // Ternary muxes (rather than if/else) so an X on CE or LSR poisons the affected state.
  always_comb begin
    lsr_act = LSR & (LsrOverCe | CE);
    s_in[0] = D;
    o_in[0] = OE_IN;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      s_in[i] = s_q[i-1];
      o_in[i] = o_q[i-1];
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      s_d[i] = lsr_act ? INIT : (CE ? s_in[i] : s_q[i]);
      o_d[i] = lsr_act ? 1'b0 : (CE ? o_in[i] : o_q[i]);
    end
    cnt_inc = (cnt_q == CntFull) ? cnt_q : cnt_q + CntW'(1);
    cnt_d   = lsr_act ? '0 : (CE ? cnt_inc : cnt_q);
  end

  always_ff @(posedge SCLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        s_q[i] <= INIT;
      end
      o_q   <= '0;
      cnt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        s_q[i] <= s_d[i];
      end
      o_q   <= o_d;
      cnt_q <= cnt_d;
    end
  end

  assign Q      = s_q[DEPTH-1];
  assign QOE    = o_q[DEPTH-1];
  assign QVALID = (cnt_q == CntFull);

endmodule

// File: tb/tb_ofd_pipe_reg.sv
// Directed bench for ofd_pipe_reg: four instances covering DEPTH=3/2/1 and both LSR_OVER_CE modes.
module tb_ofd_pipe_reg;

  logic       clk = 1'b0;
  logic       rst, ce, lsr, oe, d1;
  logic [7:0] d;

  logic [7:0] a_q, b_q, c_q;
  logic       a_qoe, b_qoe, c_qoe, e_qoe;
  logic       a_qv, b_qv, c_qv, e_qv;
  logic [0:0] e_q;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ofd_pipe_reg #(.WIDTH(8), .DEPTH(3), .INIT(8'hA5), .LSR_OVER_CE("ENABLED")) u_a (
    .SCLK(clk), .RST(rst), .CE(ce), .LSR(lsr), .D(d), .OE_IN(oe),
    .Q(a_q), .QOE(a_qoe), .QVALID(a_qv)
  );

  ofd_pipe_reg #(.WIDTH(8), .DEPTH(2), .INIT(8'h3C), .LSR_OVER_CE("ENABLED")) u_b (
    .SCLK(clk), .RST(rst), .CE(ce), .LSR(lsr), .D(d), .OE_IN(oe),
    .Q(b_q), .QOE(b_qoe), .QVALID(b_qv)
  );

  ofd_pipe_reg #(.WIDTH(8), .DEPTH(2), .INIT(8'h3C), .LSR_OVER_CE("DISABLED")) u_c (
    .SCLK(clk), .RST(rst), .CE(ce), .LSR(lsr), .D(d), .OE_IN(oe),
    .Q(c_q), .QOE(c_qoe), .QVALID(c_qv)
  );

  ofd_pipe_reg #(.WIDTH(1), .DEPTH(1), .INIT(1'b0), .LSR_OVER_CE("ENABLED")) u_e (
    .SCLK(clk), .RST(rst), .CE(ce), .LSR(lsr), .D(d1), .OE_IN(oe),
    .Q(e_q), .QOE(e_qoe), .QVALID(e_qv)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and land 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [4:0] pat;
    rst = 1'b1; ce = 1'b0; lsr = 1'b0; oe = 1'b0; d = 8'h00; d1 = 1'b0;
    pat = 5'b01101;

    // Reset values, before any edge
    #1;
    check("rst_a_q", a_q, 8'hA5);
    check("rst_a_qoe", a_qoe, 1'b0);
    check("rst_a_qv", a_qv, 1'b0);
    check("rst_b_q", b_q, 8'h3C);
    check("rst_e_q", e_q, 1'b0);

    // Latency / fill
    tick();
    rst = 1'b0; ce = 1'b1; oe = 1'b1;
    d = 8'h01; tick();
    d = 8'h02; tick();
    check("fill2_a_q", a_q, 8'hA5);
    check("fill2_a_qv", a_qv, 1'b0);
    check("fill2_b_q", b_q, 8'h01);
    check("fill2_b_qv", b_qv, 1'b1);
    d = 8'h03; tick();
    check("fill3_a_q", a_q, 8'h01);
    check("fill3_a_qoe", a_qoe, 1'b1);
    check("fill3_a_qv", a_qv, 1'b1);
    d = 8'h04; tick();
    check("fill4_a_q", a_q, 8'h02);

    // Async reset mid-stream takes effect without an edge
    rst = 1'b1;
    #1;
    check("midrst_a_q", a_q, 8'hA5);
    check("midrst_a_qoe", a_qoe, 1'b0);
    check("midrst_a_qv", a_qv, 1'b0);
    d = 8'h77; tick(); tick();
    check("rsthold_a_q", a_q, 8'hA5);
    check("rsthold_a_qv", a_qv, 1'b0);
    rst = 1'b0;
    d = 8'h10; tick();
    check("rel1_a_q", a_q, 8'hA5);
    check("rel1_a_qv", a_qv, 1'b0);
    d = 8'h11; tick();
    d = 8'h12; tick();
    check("rel3_a_q", a_q, 8'h10);
    check("rel3_a_qv", a_qv, 1'b1);

    // CE stall after one enabled edge
    reset_pulse();
    ce = 1'b1; oe = 1'b1; d = 8'h21; tick();
    ce = 1'b0; oe = 1'b0; d = 8'h99;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_a_q", a_q, 8'hA5);
      check("stall_a_qoe", a_qoe, 1'b0);
      check("stall_a_qv", a_qv, 1'b0);
    end
    ce = 1'b1; d = 8'h22; tick();
    check("resume1_a_q", a_q, 8'hA5);
    d = 8'h23; tick();
    check("resume2_a_q", a_q, 8'h21);
    check("resume2_a_qoe", a_qoe, 1'b1);
    check("resume2_a_qv", a_qv, 1'b1);

    // LSR with CE=0: honoured only when LSR_OVER_CE is ENABLED
    ce = 1'b1; oe = 1'b1;
    d = 8'h44; tick();
    d = 8'h55; tick();
    check("full_b_q", b_q, 8'h44);
    check("full_c_qv", c_qv, 1'b1);
    ce = 1'b0; lsr = 1'b1; tick();
    lsr = 1'b0;
    check("lsr_en_b_q", b_q, 8'h3C);
    check("lsr_en_b_qoe", b_qoe, 1'b0);
    check("lsr_en_b_qv", b_qv, 1'b0);
    check("lsr_dis_c_q", c_q, 8'h44);
    check("lsr_dis_c_qv", c_qv, 1'b1);

    // LSR and CE on the same edge: clear wins, FF never reaches Q
    ce = 1'b1; lsr = 1'b1; d = 8'hFF; tick();
    lsr = 1'b0;
    check("sim_b_q", b_q, 8'h3C);
    check("sim_b_qv", b_qv, 1'b0);
    check("sim_c_q", c_q, 8'h3C);
    check("sim_a_q", a_q, 8'hA5);
    check("sim_a_qv", a_qv, 1'b0);
    d = 8'h01; tick();
    check("sim1_b_q", b_q, 8'h3C);
    check("sim1_b_qv", b_qv, 1'b0);
    d = 8'h02; tick();
    check("sim2_b_q", b_q, 8'h01);
    check("sim2_b_qv", b_qv, 1'b1);

    // DEPTH=1, WIDTH=1: Q is D one edge late
    reset_pulse();
    check("d1_e_qv0", e_qv, 1'b0);
    ce = 1'b1;
    for (int i = 0; i < 5; i++) begin
      d1 = pat[i];
      tick();
      check("d1_e_q", e_q, pat[i]);
      check("d1_e_qv", e_qv, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
